huffman_seq_ctrl: RTL and testbench
===================================

Name: huffman_seq_ctrl

Overview:
- Top-level sequencer for the Huffman encode pipeline: frequency counter -> tree_construct -> code generator -> encoder.
- Issues one-cycle start pulses to each stage and waits for that stage's completion.
- Short-circuits degenerate alphabets (0 or 1 distinct symbols) and reinitialises the datapath before every run via a sub-block reset.
- Sits between the host start/abort interface and the datapath blocks.

Parameters:
- RST_CYCLES, 2: cycles sub_reset_n is held low in CLEAR (1..15).
- TIMEOUT_CYCLES, 65535: per-stage watchdog limit, 16-bit (used only with HUFF_CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  host request to run; level-sampled in IDLE, DONE or ERROR
- abort  in  1  host abort; cancels any run
- symbol_count  in  8  number of nonzero symbol counts (0..128); valid in the cycle count_done rises
- count_done  in  1  counter stage complete (level; may stay high)
- build_tree_finish  in  1  tree builder complete (level; stays high until that block is reset)
- codegen_done  in  1  code generator complete (level)
- encode_done  in  1  encoder complete (level)
- sub_reset_n  out  1  active-low reset to the datapath blocks
- count_start, build_tree_start, codegen_start, encode_start  out  1 each  one-cycle start pulses
- single_sym  out  1  alphabet has exactly one symbol; tree build skipped
- empty  out  1  alphabet has no symbols
- busy  out  1  high in CLEAR, COUNT, BUILD, CODEGEN, ENCODE
- done  out  1  one-cycle completion pulse
- timeout_err  out  1  sticky watchdog error
- stage  out  3  current state code

Behaviour:
- All outputs are registered.
- Reset values: sub_reset_n=0, all start pulses=0, single_sym=0, empty=0, busy=0, done=0, timeout_err=0, stage=IDLE.
- State codes: IDLE=0, CLEAR=1, COUNT=2, BUILD=3, CODEGEN=4, ENCODE=5, DONE=6, ERROR=7.
- Done detection: each done input is rising-edge detected (in & ~prev), with prev registers reset to 0. An edge is honoured only in its matching state; edges seen in any other state are discarded.
- IDLE:
  - sub_reset_n=1.
  - start=1 and abort=0 -> CLEAR; single_sym, empty and timeout_err clear on entry to CLEAR.
- CLEAR:
  - sub_reset_n=0 for exactly RST_CYCLES cycles, then -> COUNT.
  - If CLEAR was entered via abort, go -> IDLE instead.
- COUNT: count_start=1 in the first cycle only. On a count_done edge, decide on the symbol_count value in that same cycle:
  - 0 -> empty=1, go DONE.
  - 1 -> single_sym=1, go CODEGEN.
  - >=2 -> BUILD.
- BUILD: build_tree_start=1 in the first cycle; build_tree_finish edge -> CODEGEN.
- CODEGEN: codegen_start=1 in the first cycle; codegen_done edge -> ENCODE.
- ENCODE: encode_start=1 in the first cycle; encode_done edge -> DONE.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE.
  - single_sym and empty hold until the next CLEAR.
- Latency: a start pulse appears on the clock edge that enters the state. The next state is entered on the clock edge after the done edge is sampled.
- start while busy: ignored (no queuing).
- abort in any busy state -> CLEAR (abort path, then IDLE); no done pulse. abort has priority over a done edge and over start in the same cycle.
- Asynchronous reset mid-run returns to the reset values immediately; sub_reset_n=0 resets the datapath as well.
- A symbol_count value above 128 is treated as >=2.

Optional Feature:
- HUFF_CTRL_TIMEOUT_EN defined:
  - A 16-bit watchdog counter clears on entry to COUNT, BUILD, CODEGEN and ENCODE, and increments every cycle spent in them.
  - Reaching TIMEOUT_CYCLES without the matching done edge -> ERROR: timeout_err=1 (sticky), sub_reset_n=0 held, busy=0.
  - ERROR exits only on start -> CLEAR, which clears timeout_err. abort in ERROR is ignored.
- HUFF_CTRL_TIMEOUT_EN undefined: no counter is built, timeout_err is tied to 0, and ERROR is unreachable.

Test Plan:
- Normal run: start; count_done with symbol_count=5; finish edge 300 cycles later; codegen_done; encode_done -> sub_reset_n low exactly 2 cycles; each start pulse exactly 1 cycle, in order; done exactly 1 cycle; stage walks 1,2,3,4,5,6,0.
- Back-to-back runs with build_tree_finish left high from run 1 -> run 2 waits in BUILD until the line drops under sub reset and rises again; no early advance to CODEGEN.
- Degenerate alphabets: symbol_count=0 -> empty=1, done pulse, no other start pulses. symbol_count=1 -> single_sym=1, build_tree_start never asserts, codegen_start follows count_done.
- Abort in BUILD, in the same cycle as a build_tree_finish edge -> CLEAR with sub_reset_n low 2 cycles, then IDLE; no done pulse, no codegen_start.
- start held high through the whole run -> exactly one run while busy. Because start is level-sampled in DONE/IDLE, a new run then begins (CLEAR) immediately after the done pulse; deassert start before done to get a single run.
- Timeout: with HUFF_CTRL_TIMEOUT_EN defined and TIMEOUT_CYCLES=100, withhold codegen_done -> ERROR after 100 cycles in CODEGEN, timeout_err=1, busy=0; a later start clears timeout_err. Without the macro, the same stimulus stays in CODEGEN indefinitely.

Source files
------------

// File: rtl/huffman_seq_ctrl_if.sv
// Handshake bundle between the Huffman sequencer, its host and the datapath stages.
// The controller takes the slave view; the host/datapath side takes the master view.
interface huffman_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic [7:0] symbol_count;
    logic       count_done;
    logic       build_tree_finish;
    logic       codegen_done;
    logic       encode_done;
    logic       sub_reset_n;
    logic       count_start;
    logic       build_tree_start;
    logic       codegen_start;
    logic       encode_start;
    logic       single_sym;
    logic       empty;
    logic       busy;
    logic       done;
    logic       timeout_err;
    logic [2:0] stage;

    modport slave (
        input  start, abort, symbol_count,
        input  count_done, build_tree_finish, codegen_done, encode_done,
        output sub_reset_n, count_start, build_tree_start, codegen_start, encode_start,
        output single_sym, empty, busy, done, timeout_err, stage
    );

    modport master (
        output start, abort, symbol_count,
        output count_done, build_tree_finish, codegen_done, encode_done,
        input  sub_reset_n, count_start, build_tree_start, codegen_start, encode_start,
        input  single_sym, empty, busy, done, timeout_err, stage
    );
endinterface

// File: rtl/huffman_seq_ctrl.sv
// Sequencer for the Huffman encode pipeline: count -> tree build -> codegen -> encode.
// Optional per-stage watchdog enabled by defining HUFF_CTRL_TIMEOUT_EN.
module huffman_seq_ctrl #(
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    huffman_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COUNT   = 3'd2,
        S_BUILD   = 3'd3,
        S_CODEGEN = 3'd4,
        S_ENCODE  = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rst_cnt_q, rst_cnt_d;
    logic       abort_path_q, abort_path_d;
    logic [3:0] prev_q, prev_d;
    logic       sub_reset_n_q, sub_reset_n_d;
    logic       count_start_q, count_start_d;
    logic       build_tree_start_q, build_tree_start_d;
    logic       codegen_start_q, codegen_start_d;
    logic       encode_start_q, encode_start_d;
    logic       single_sym_q, single_sym_d;
    logic       empty_q, empty_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       clear_req, clear_abort;
    logic       cnt_edge, bld_edge, cg_edge, enc_edge;
`ifdef HUFF_CTRL_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        timeout_err_q, timeout_err_d;
    logic        wd_expired;
`endif

    assign cnt_edge = bus.count_done        & ~prev_q[0];
    assign bld_edge = bus.build_tree_finish & ~prev_q[1];
    assign cg_edge  = bus.codegen_done      & ~prev_q[2];
    assign enc_edge = bus.encode_done       & ~prev_q[3];
`ifdef HUFF_CTRL_TIMEOUT_EN
    assign wd_expired = (wd_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d            = state_q;
        rst_cnt_d          = rst_cnt_q;
        abort_path_d       = abort_path_q;
        prev_d             = {bus.encode_done, bus.codegen_done, bus.build_tree_finish, bus.count_done};
        count_start_d      = 1'b0;
        build_tree_start_d = 1'b0;
        codegen_start_d    = 1'b0;
        encode_start_d     = 1'b0;
        done_d             = 1'b0;
        single_sym_d       = single_sym_q;
        empty_d            = empty_q;
        clear_req          = 1'b0;
        clear_abort        = 1'b0;
`ifdef HUFF_CTRL_TIMEOUT_EN
        timeout_err_d      = timeout_err_q;
        wd_d               = wd_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) clear_req = 1'b1;
            end
            S_CLEAR: begin
                if (bus.abort) begin
                    clear_req   = 1'b1;
                    clear_abort = 1'b1;
                end else if (rst_cnt_q == 4'(RST_CYCLES - 1)) begin
                    if (abort_path_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d       = S_COUNT;
                        count_start_d = 1'b1;
                    end
                end else begin
                    rst_cnt_d = rst_cnt_q + 4'd1;
                end
            end
            S_COUNT: begin
                if (bus.abort) begin
                    clear_req   = 1'b1;
                    clear_abort = 1'b1;
                end else if (cnt_edge) begin
                    // Decision uses symbol_count from the same cycle as the done edge.
                    if (bus.symbol_count == 8'd0) begin
                        empty_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (bus.symbol_count == 8'd1) begin
                        single_sym_d    = 1'b1;
                        codegen_start_d = 1'b1;
                        state_d         = S_CODEGEN;
                    end else begin
                        build_tree_start_d = 1'b1;
                        state_d            = S_BUILD;
                    end
                end
`ifdef HUFF_CTRL_TIMEOUT_EN
                else if (wd_expired) state_d = S_ERROR;
`endif
            end
            S_BUILD: begin
                if (bus.abort) begin
                    clear_req   = 1'b1;
                    clear_abort = 1'b1;
                end else if (bld_edge) begin
                    codegen_start_d = 1'b1;
                    state_d         = S_CODEGEN;
                end
`ifdef HUFF_CTRL_TIMEOUT_EN
                else if (wd_expired) state_d = S_ERROR;
`endif
            end
            S_CODEGEN: begin
                if (bus.abort) begin
                    clear_req   = 1'b1;
                    clear_abort = 1'b1;
                end else if (cg_edge) begin
                    encode_start_d = 1'b1;
                    state_d        = S_ENCODE;
                end
`ifdef HUFF_CTRL_TIMEOUT_EN
                else if (wd_expired) state_d = S_ERROR;
`endif
            end
            S_ENCODE: begin
                if (bus.abort) begin
                    clear_req   = 1'b1;
                    clear_abort = 1'b1;
                end else if (enc_edge) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
`ifdef HUFF_CTRL_TIMEOUT_EN
                else if (wd_expired) state_d = S_ERROR;
`endif
            end
            S_DONE: begin
                // start is level-sampled here, so a held start chains straight into another run.
                if (bus.start && !bus.abort) clear_req = 1'b1;
                else                         state_d   = S_IDLE;
            end
            S_ERROR: begin
                if (bus.start) clear_req = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef HUFF_CTRL_TIMEOUT_EN
        if (state_d == S_ERROR) timeout_err_d = 1'b1;
        if (state_d != state_q) wd_d = '0;
        else if (state_q inside {S_COUNT, S_BUILD, S_CODEGEN, S_ENCODE}) wd_d = wd_q + 16'd1;
`endif

        if (clear_req) begin
            state_d      = S_CLEAR;
            rst_cnt_d    = '0;
            abort_path_d = clear_abort;
            single_sym_d = 1'b0;
            empty_d      = 1'b0;
`ifdef HUFF_CTRL_TIMEOUT_EN
            timeout_err_d = 1'b0;
`endif
        end

        sub_reset_n_d = !(state_d == S_CLEAR || state_d == S_ERROR);
        busy_d        = state_d inside {S_CLEAR, S_COUNT, S_BUILD, S_CODEGEN, S_ENCODE};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= S_IDLE;
            rst_cnt_q          <= '0;
            abort_path_q       <= 1'b0;
            prev_q             <= '0;
            sub_reset_n_q      <= 1'b0;
            count_start_q      <= 1'b0;
            build_tree_start_q <= 1'b0;
            codegen_start_q    <= 1'b0;
            encode_start_q     <= 1'b0;
            single_sym_q       <= 1'b0;
            empty_q            <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
`ifdef HUFF_CTRL_TIMEOUT_EN
            wd_q               <= '0;
            timeout_err_q      <= 1'b0;
`endif
        end else begin
            state_q            <= state_d;
            rst_cnt_q          <= rst_cnt_d;
            abort_path_q       <= abort_path_d;
            prev_q             <= prev_d;
            sub_reset_n_q      <= sub_reset_n_d;
            count_start_q      <= count_start_d;
            build_tree_start_q <= build_tree_start_d;
            codegen_start_q    <= codegen_start_d;
            encode_start_q     <= encode_start_d;
            single_sym_q       <= single_sym_d;
            empty_q            <= empty_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
`ifdef HUFF_CTRL_TIMEOUT_EN
            wd_q               <= wd_d;
            timeout_err_q      <= timeout_err_d;
`endif
        end
    end

    assign bus.sub_reset_n      = sub_reset_n_q;
    assign bus.count_start      = count_start_q;
    assign bus.build_tree_start = build_tree_start_q;
    assign bus.codegen_start    = codegen_start_q;
    assign bus.encode_start     = encode_start_q;
    assign bus.single_sym       = single_sym_q;
    assign bus.empty            = empty_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.stage            = state_q;
`ifdef HUFF_CTRL_TIMEOUT_EN
    assign bus.timeout_err      = timeout_err_q;
`else
    assign bus.timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_huffman_seq_ctrl.sv
// Directed bench for huffman_seq_ctrl (RST_CYCLES=2, TIMEOUT_CYCLES=100).
// Timeout scenario follows whether HUFF_CTRL_TIMEOUT_EN is defined.
module tb_huffman_seq_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    huffman_seq_ctrl_if bus ();

    huffman_seq_ctrl #(
        .RST_CYCLES    (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Pulse counters, stage history and sub-reset low-run length, sampled mid-cycle.
    int          n_cs = 0, n_bts = 0, n_cgs = 0, n_es = 0, n_done = 0;
    int          low_run = 0, low_last = 0;
    logic [31:0] stage_log = '0;
    logic [2:0]  last_stage = 3'd0;

    always @(negedge clk) begin
        if (bus.count_start)      n_cs   <= n_cs + 1;
        if (bus.build_tree_start) n_bts  <= n_bts + 1;
        if (bus.codegen_start)    n_cgs  <= n_cgs + 1;
        if (bus.encode_start)     n_es   <= n_es + 1;
        if (bus.done)             n_done <= n_done + 1;
        if (bus.stage != last_stage) begin
            stage_log  <= {stage_log[28:0], bus.stage};
            last_stage <= bus.stage;
        end
        if (!bus.sub_reset_n) begin
            low_run <= low_run + 1;
        end else begin
            if (low_run != 0) low_last <= low_run;
            low_run <= 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "bench did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_lines();
        bus.count_done        = 1'b0;
        bus.build_tree_finish = 1'b0;
        bus.codegen_done      = 1'b0;
        bus.encode_done       = 1'b0;
    endtask

    task automatic wait_stage(input logic [2:0] exp, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.stage == exp) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (bus.stage == exp) ok = 1'b1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0; bus.symbol_count = 8'd0;
        drop_lines();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.sub_reset_n, bus.count_start, bus.build_tree_start, bus.codegen_start, bus.encode_start,
             bus.single_sym, bus.empty, bus.busy, bus.done, bus.timeout_err, bus.stage} !== 13'd0)
            begin errors++; $display("FAIL reset_values got %b want all zero",
                {bus.sub_reset_n, bus.count_start, bus.build_tree_start, bus.codegen_start, bus.encode_start,
                 bus.single_sym, bus.empty, bus.busy, bus.done, bus.timeout_err, bus.stage}); end
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.sub_reset_n, bus.busy, bus.stage} !== {1'b1, 1'b0, 3'd0})
            begin errors++; $display("FAIL idle_after_reset got srn=%b busy=%b stage=%0d want 1 0 0",
                bus.sub_reset_n, bus.busy, bus.stage); end
    endtask

    task automatic test_normal();
        bit ok;
        int b_cs = n_cs, b_bts = n_bts, b_cgs = n_cgs, b_es = n_es, b_done = n_done;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.stage, bus.sub_reset_n, bus.busy} !== {3'd1, 1'b0, 1'b1})
            begin errors++; $display("FAIL normal_clear_entry got stage=%0d srn=%b busy=%b want 1 0 1",
                bus.stage, bus.sub_reset_n, bus.busy); end
        wait_stage(3'd2, 10, ok);
        checks++;
        if (!ok || bus.count_start !== 1'b1)
            begin errors++; $display("FAIL normal_count_entry got stage=%0d cs=%b want 2 1", bus.stage, bus.count_start); end
        tick();
        bus.symbol_count = 8'd5; bus.count_done = 1'b1;
        tick();
        checks++;
        if ({bus.stage, bus.build_tree_start} !== {3'd3, 1'b1})
            begin errors++; $display("FAIL normal_build_entry got stage=%0d bts=%b want 3 1", bus.stage, bus.build_tree_start); end
        repeat (300) tick();
        checks++;
        if (bus.stage !== 3'd3)
            begin errors++; $display("FAIL normal_build_wait got stage=%0d want 3", bus.stage); end
        bus.build_tree_finish = 1'b1;
        tick();
        checks++;
        if ({bus.stage, bus.codegen_start} !== {3'd4, 1'b1})
            begin errors++; $display("FAIL normal_codegen_entry got stage=%0d cgs=%b want 4 1", bus.stage, bus.codegen_start); end
        bus.codegen_done = 1'b1;
        tick();
        checks++;
        if ({bus.stage, bus.encode_start} !== {3'd5, 1'b1})
            begin errors++; $display("FAIL normal_encode_entry got stage=%0d es=%b want 5 1", bus.stage, bus.encode_start); end
        bus.encode_done = 1'b1;
        tick();
        checks++;
        if ({bus.stage, bus.done, bus.busy} !== {3'd6, 1'b1, 1'b0})
            begin errors++; $display("FAIL normal_done got stage=%0d done=%b busy=%b want 6 1 0", bus.stage, bus.done, bus.busy); end
        tick();
        checks++;
        if ({bus.stage, bus.done} !== {3'd0, 1'b0})
            begin errors++; $display("FAIL normal_idle got stage=%0d done=%b want 0 0", bus.stage, bus.done); end
        tick();
        checks++;
        if ({4'(n_cs - b_cs), 4'(n_bts - b_bts), 4'(n_cgs - b_cgs), 4'(n_es - b_es), 4'(n_done - b_done)} !== 20'h11111)
            begin errors++; $display("FAIL normal_pulse_counts got cs=%0d bts=%0d cgs=%0d es=%0d done=%0d want 1 each",
                n_cs - b_cs, n_bts - b_bts, n_cgs - b_cgs, n_es - b_es, n_done - b_done); end
        checks++;
        if (low_last !== 2)
            begin errors++; $display("FAIL normal_sub_reset_len got %0d want 2", low_last); end
        checks++;
        if (stage_log[20:0] !== {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0})
            begin errors++; $display("FAIL normal_stage_walk got %h want %h", stage_log[20:0],
                21'({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0})); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int b_done = n_done;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.count_done = 1'b0; bus.codegen_done = 1'b0; bus.encode_done = 1'b0;
        wait_stage(3'd2, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_reach_count got stage=%0d want 2", bus.stage); end
        bus.symbol_count = 8'd200; bus.count_done = 1'b1;
        tick();
        checks++;
        if (bus.stage !== 3'd3)
            begin errors++; $display("FAIL b2b_big_count_build got stage=%0d want 3", bus.stage); end
        repeat (5) tick();
        checks++;
        if (bus.stage !== 3'd3)
            begin errors++; $display("FAIL b2b_stale_finish got stage=%0d want 3", bus.stage); end
        bus.build_tree_finish = 1'b0;
        tick();
        bus.build_tree_finish = 1'b1;
        tick();
        checks++;
        if (bus.stage !== 3'd4)
            begin errors++; $display("FAIL b2b_fresh_finish got stage=%0d want 4", bus.stage); end
        bus.codegen_done = 1'b1;
        tick();
        bus.encode_done = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({bus.stage, 4'(n_done - b_done)} !== {3'd0, 4'd1})
            begin errors++; $display("FAIL b2b_complete got stage=%0d done_pulses=%0d want 0 1", bus.stage, n_done - b_done); end
    endtask

    task automatic test_empty();
        bit ok;
        int b_cs = n_cs, b_bts = n_bts, b_cgs = n_cgs, b_es = n_es, b_done = n_done;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drop_lines();
        wait_stage(3'd2, 10, ok);
        bus.symbol_count = 8'd0; bus.count_done = 1'b1;
        tick();
        checks++;
        if (!ok || {bus.stage, bus.done, bus.empty, bus.single_sym} !== {3'd6, 1'b1, 1'b1, 1'b0})
            begin errors++; $display("FAIL empty_done got stage=%0d done=%b empty=%b single=%b want 6 1 1 0",
                bus.stage, bus.done, bus.empty, bus.single_sym); end
        tick();
        checks++;
        if ({bus.stage, bus.empty, bus.done} !== {3'd0, 1'b1, 1'b0})
            begin errors++; $display("FAIL empty_hold got stage=%0d empty=%b done=%b want 0 1 0", bus.stage, bus.empty, bus.done); end
        tick();
        checks++;
        if ({4'(n_cs - b_cs), 4'(n_bts - b_bts), 4'(n_cgs - b_cgs), 4'(n_es - b_es), 4'(n_done - b_done)} !== 20'h10001)
            begin errors++; $display("FAIL empty_pulses got cs=%0d bts=%0d cgs=%0d es=%0d done=%0d want 1 0 0 0 1",
                n_cs - b_cs, n_bts - b_bts, n_cgs - b_cgs, n_es - b_es, n_done - b_done); end
    endtask

    task automatic test_single();
        bit ok;
        int b_bts = n_bts, b_cgs = n_cgs, b_done = n_done;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.stage, bus.empty} !== {3'd1, 1'b0})
            begin errors++; $display("FAIL single_clear_flags got stage=%0d empty=%b want 1 0", bus.stage, bus.empty); end
        drop_lines();
        wait_stage(3'd2, 10, ok);
        bus.symbol_count = 8'd1; bus.count_done = 1'b1;
        tick();
        checks++;
        if (!ok || {bus.stage, bus.single_sym, bus.codegen_start} !== {3'd4, 1'b1, 1'b1})
            begin errors++; $display("FAIL single_codegen got stage=%0d single=%b cgs=%b want 4 1 1",
                bus.stage, bus.single_sym, bus.codegen_start); end
        bus.codegen_done = 1'b1;
        tick();
        bus.encode_done = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({bus.stage, bus.single_sym, 4'(n_bts - b_bts), 4'(n_cgs - b_cgs), 4'(n_done - b_done)} !== {3'd0, 1'b1, 4'd0, 4'd1, 4'd1})
            begin errors++; $display("FAIL single_finish got stage=%0d single=%b bts=%0d cgs=%0d done=%0d want 0 1 0 1 1",
                bus.stage, bus.single_sym, n_bts - b_bts, n_cgs - b_cgs, n_done - b_done); end
    endtask

    task automatic test_abort();
        bit ok;
        int b_cgs = n_cgs, b_done = n_done;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.stage, bus.single_sym} !== {3'd1, 1'b0})
            begin errors++; $display("FAIL abort_clear_flags got stage=%0d single=%b want 1 0", bus.stage, bus.single_sym); end
        drop_lines();
        wait_stage(3'd2, 10, ok);
        bus.symbol_count = 8'd3; bus.count_done = 1'b1;
        tick();
        repeat (2) tick();
        bus.abort = 1'b1; bus.build_tree_finish = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if (!ok || {bus.stage, bus.sub_reset_n, bus.busy} !== {3'd1, 1'b0, 1'b1})
            begin errors++; $display("FAIL abort_to_clear got stage=%0d srn=%b busy=%b want 1 0 1",
                bus.stage, bus.sub_reset_n, bus.busy); end
        tick();
        tick();
        checks++;
        if ({bus.stage, bus.busy, bus.sub_reset_n} !== {3'd0, 1'b0, 1'b1})
            begin errors++; $display("FAIL abort_to_idle got stage=%0d busy=%b srn=%b want 0 0 1",
                bus.stage, bus.busy, bus.sub_reset_n); end
        tick();
        checks++;
        if ({4'(n_cgs - b_cgs), 4'(n_done - b_done), 4'(low_last)} !== {4'd0, 4'd0, 4'd2})
            begin errors++; $display("FAIL abort_side_effects got cgs=%0d done=%0d srn_low=%0d want 0 0 2",
                n_cgs - b_cgs, n_done - b_done, low_last); end
    endtask

    task automatic test_start_held();
        bit ok;
        int b_cs = n_cs, b_done = n_done;
        bus.start = 1'b1;
        tick();
        drop_lines();
        wait_stage(3'd2, 10, ok);
        repeat (3) tick();
        checks++;
        if (!ok || {bus.stage, 4'(n_cs - b_cs)} !== {3'd2, 4'd1})
            begin errors++; $display("FAIL held_no_requeue got stage=%0d cs=%0d want 2 1", bus.stage, n_cs - b_cs); end
        bus.symbol_count = 8'd0; bus.count_done = 1'b1;
        tick();
        checks++;
        if ({bus.stage, bus.done} !== {3'd6, 1'b1})
            begin errors++; $display("FAIL held_done got stage=%0d done=%b want 6 1", bus.stage, bus.done); end
        tick();
        checks++;
        if ({bus.stage, bus.empty, bus.done} !== {3'd1, 1'b0, 1'b0})
            begin errors++; $display("FAIL held_rerun got stage=%0d empty=%b done=%b want 1 0 0", bus.stage, bus.empty, bus.done); end
        bus.start = 1'b0;
        drop_lines();
        wait_stage(3'd2, 10, ok);
        bus.count_done = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (!ok || {bus.stage, 4'(n_cs - b_cs), 4'(n_done - b_done)} !== {3'd0, 4'd2, 4'd2})
            begin errors++; $display("FAIL held_two_runs got stage=%0d cs=%0d done=%0d want 0 2 2",
                bus.stage, n_cs - b_cs, n_done - b_done); end
    endtask

    task automatic test_timeout();
        bit ok;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drop_lines();
        wait_stage(3'd2, 10, ok);
        bus.symbol_count = 8'd1; bus.count_done = 1'b1;
        tick();
        checks++;
        if (!ok || bus.stage !== 3'd4)
            begin errors++; $display("FAIL timeout_reach_codegen got stage=%0d want 4", bus.stage); end
`ifdef HUFF_CTRL_TIMEOUT_EN
        repeat (99) tick();
        checks++;
        if ({bus.stage, bus.timeout_err} !== {3'd4, 1'b0})
            begin errors++; $display("FAIL timeout_early got stage=%0d terr=%b want 4 0", bus.stage, bus.timeout_err); end
        tick();
        checks++;
        if ({bus.stage, bus.timeout_err, bus.busy, bus.sub_reset_n} !== {3'd7, 1'b1, 1'b0, 1'b0})
            begin errors++; $display("FAIL timeout_error got stage=%0d terr=%b busy=%b srn=%b want 7 1 0 0",
                bus.stage, bus.timeout_err, bus.busy, bus.sub_reset_n); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checks++;
        if ({bus.stage, bus.timeout_err} !== {3'd7, 1'b1})
            begin errors++; $display("FAIL timeout_abort_ignored got stage=%0d terr=%b want 7 1", bus.stage, bus.timeout_err); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if ({bus.stage, bus.timeout_err} !== {3'd1, 1'b0})
            begin errors++; $display("FAIL timeout_restart got stage=%0d terr=%b want 1 0", bus.stage, bus.timeout_err); end
        drop_lines();
        wait_stage(3'd2, 10, ok);
`else
        repeat (150) tick();
        checks++;
        if ({bus.stage, bus.timeout_err, bus.busy} !== {3'd4, 1'b0, 1'b1})
            begin errors++; $display("FAIL no_timeout got stage=%0d terr=%b busy=%b want 4 0 1",
                bus.stage, bus.timeout_err, bus.busy); end
`endif
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        wait_stage(3'd0, 10, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_cleanup got stage=%0d want 0", bus.stage); end
    endtask

    task automatic test_async_reset();
        bit ok;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        drop_lines();
        wait_stage(3'd2, 10, ok);
        bus.symbol_count = 8'd2; bus.count_done = 1'b1;
        tick();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (!ok || {bus.sub_reset_n, bus.count_start, bus.build_tree_start, bus.codegen_start, bus.encode_start,
             bus.single_sym, bus.empty, bus.busy, bus.done, bus.timeout_err, bus.stage} !== 13'd0)
            begin errors++; $display("FAIL async_reset got srn=%b bts=%b busy=%b stage=%0d want all zero",
                bus.sub_reset_n, bus.build_tree_start, bus.busy, bus.stage); end
        drop_lines();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.stage, bus.sub_reset_n, bus.busy} !== {3'd0, 1'b1, 1'b0})
            begin errors++; $display("FAIL async_reset_release got stage=%0d srn=%b busy=%b want 0 1 0",
                bus.stage, bus.sub_reset_n, bus.busy); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_back_to_back();
        test_empty();
        test_single();
        test_abort();
        test_start_held();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
